// File: rtl/btn_pkg.sv
// btn_pkg -- shared types and helpers for the push-button conditioner.
//   btn_state_t : per-channel press-tracking FSM states
//   tick_div()  : IN_CLK cycles per 1 ms tick for a given clock frequency
//   cnt_width() : bits needed to hold a count of 0..max_val (never 0 bits)
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_t;

  function automatic int tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Widths for the default parameter set.
  localparam int DEF_STAB_W = cnt_width(10);
  localparam int DEF_HOLD_W = cnt_width(1000);

endpackage

// File: rtl/btn_channel.sv
// btn_channel -- one button: 2-FF synchroniser, tick-based debouncer and
// press / release / long-press FSM.
// Optional: define BTN_AUTOREPEAT_EN to re-pulse press every REPEAT_MS ticks
// while in LONG_HELD.
//   IN_CLK        : clock
//   reset         : synchronous, active-high reset
//   tick          : 1 ms tick from the shared prescaler
//   btn_raw       : raw asynchronous button level (1 = pressed)
//   level         : debounced level
//   press_pulse   : 1-cycle pulse on debounced press (and on auto-repeat)
//   release_pulse : 1-cycle pulse on debounced release
//   long_pulse    : 1-cycle pulse once per hold, LONG_MS ticks after press
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic IN_CLK,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int STAB_W = cnt_width(DEBOUNCE_MS);
  localparam int HOLD_W = cnt_width(LONG_MS);
  // Level flips on the tick that would bring the stable count to DEBOUNCE_MS.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic                level_q, level_d;
  btn_state_t          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                long_q, long_d;
`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_MS);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_MS);
  logic [REP_W-1:0]    rep_q, rep_d;
`endif

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    stab_d    = stab_q;
    level_d   = level_q;
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif

    // Debouncer: count consecutive ticks where the sample disagrees with
    // the level; any agreeing tick restarts the count.
    if (tick) begin
      if (sync2_q != level_q) begin
        if (stab_q == STAB_LAST) begin
          level_d = ~level_q;
          stab_d  = '0;
        end else begin
          stab_d  = stab_q + STAB_W'(1);
        end
      end else begin
        stab_d = '0;
      end
    end

    // Edge detection works off the level register: IDLE always has level 0,
    // HELD / LONG_HELD always level 1, so a mismatch is the edge.
    case (state_q)
      IDLE: begin
        if (level_q) begin
          press_d = 1'b1;
          hold_d  = '0;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!level_q) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (hold_q == HOLD_MAX) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
`ifdef BTN_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      LONG_HELD: begin
        if (!level_q) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rep_q == REP_MAX) begin
          press_d = 1'b1;
          rep_d   = '0;
        end else if (tick) begin
          rep_d = rep_q + REP_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge IN_CLK) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stab_q    <= '0;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stab_q    <= stab_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner -- synchronises, debounces and edge-decodes N_BTN push
// buttons against a shared 1 ms tick.
// Optional: define BTN_AUTOREPEAT_EN to enable press auto-repeat in long hold.
//   IN_CLK          : clock
//   reset           : synchronous, active-high reset
//   IN_BTN          : raw button levels, 1 = pressed
//   OUT_BTN_LEVEL   : debounced levels
//   OUT_BTN_PRESS   : 1-cycle press pulses (plus auto-repeat when enabled)
//   OUT_BTN_RELEASE : 1-cycle release pulses
//   OUT_BTN_LONG    : 1-cycle long-press pulses
//   OUT_TICK_1MS    : 1-cycle pulse every CLK_HZ/1000 cycles
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int N_BTN       = 5,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic             IN_CLK,
  input  logic             reset,
  input  logic [N_BTN-1:0] IN_BTN,
  output logic [N_BTN-1:0] OUT_BTN_LEVEL,
  output logic [N_BTN-1:0] OUT_BTN_PRESS,
  output logic [N_BTN-1:0] OUT_BTN_RELEASE,
  output logic [N_BTN-1:0] OUT_BTN_LONG,
  output logic             OUT_TICK_1MS
);

  localparam int DIV   = tick_div(CLK_HZ);
  localparam int DIV_W = cnt_width(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;

  // Tick is registered so it is high in the cycle the count has wrapped to 0.
  always_comb begin
    tick_d  = (presc_q == DIV_LAST);
    presc_d = tick_d ? '0 : presc_q + DIV_W'(1);
  end

  always_ff @(posedge IN_CLK) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign OUT_TICK_1MS = tick_q;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_channel #(
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS),
        .REPEAT_MS   (REPEAT_MS)
      ) u_ch (
        .IN_CLK        (IN_CLK),
        .reset         (reset),
        .tick          (tick_q),
        .btn_raw       (IN_BTN[gi]),
        .level         (OUT_BTN_LEVEL[gi]),
        .press_pulse   (OUT_BTN_PRESS[gi]),
        .release_pulse (OUT_BTN_RELEASE[gi]),
        .long_pulse    (OUT_BTN_LONG[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner -- directed stimulus with a scoreboard of hand-computed
// expected output events (level changes and pulses), checked by a monitor.
// Cycle n = state after the n-th rising clock edge; inputs change and outputs
// are sampled on the falling edge.
module tb_btn_conditioner;

  logic       clk;
  logic       reset;
  logic [4:0] btn;
  logic [4:0] lvl, prs, rel, lng;
  logic       tick;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
    logic [4:0] lng;
  } ev_t;

  ev_t exp_q[$];

  btn_conditioner #(
    .CLK_HZ      (10000),
    .N_BTN       (5),
    .DEBOUNCE_MS (3),
    .LONG_MS     (20),
    .REPEAT_MS   (5)
  ) dut (
    .IN_CLK          (clk),
    .reset           (reset),
    .IN_BTN          (btn),
    .OUT_BTN_LEVEL   (lvl),
    .OUT_BTN_PRESS   (prs),
    .OUT_BTN_RELEASE (rel),
    .OUT_BTN_LONG    (lng),
    .OUT_TICK_1MS    (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [4:0] l, input logic [4:0] p,
                      input logic [4:0] r, input logic [4:0] g);
    ev_t e;
    e.cyc = c; e.lvl = l; e.prs = p; e.rel = r; e.lng = g;
    exp_q.push_back(e);
  endtask

  // Stimulus: each drive pushes the events it must produce.
  initial begin
    reset = 1'b1;
    btn   = '0;
    wait_cyc(3);
    reset = 1'b0;            // ticks fall on cycles 13, 23, 33, ...

    // Clean press of button 0.
    wait_cyc(30);  btn[0] = 1'b1;
    push(54, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    push(55, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
    wait_cyc(130); btn[0] = 1'b0;
    push(154, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    push(155, 5'b00000, 5'b00000, 5'b00001, 5'b00000);

    // Button 1 bounces every 7 cycles, then settles high.
    for (int k = 0; k < 9; k++) begin
      wait_cyc(200 + 7 * k);
      btn[1] = (k % 2 == 0);
    end
    push(284, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    push(285, 5'b00010, 5'b00010, 5'b00000, 5'b00000);
    wait_cyc(400); btn[1] = 1'b0;
    push(424, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    push(425, 5'b00000, 5'b00000, 5'b00010, 5'b00000);

    // Long hold of button 2.
    wait_cyc(500); btn[2] = 1'b1;
    push(524, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    push(525, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
    push(725, 5'b00100, 5'b00000, 5'b00000, 5'b00100);
`ifdef BTN_AUTOREPEAT_EN
    push(775, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
    push(825, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
`endif
    wait_cyc(810); btn[2] = 1'b0;
    push(834, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    push(835, 5'b00000, 5'b00000, 5'b00100, 5'b00000);

    // Buttons 0 and 4 together.
    wait_cyc(900); btn[0] = 1'b1; btn[4] = 1'b1;
    push(924, 5'b10001, 5'b00000, 5'b00000, 5'b00000);
    push(925, 5'b10001, 5'b10001, 5'b00000, 5'b00000);
    wait_cyc(960); btn[0] = 1'b0; btn[4] = 1'b0;
    push(984, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    push(985, 5'b00000, 5'b00000, 5'b10001, 5'b00000);

    // Button 3 into long hold, then reset for 3 cycles while held.
    wait_cyc(1000); btn[3] = 1'b1;
    push(1024, 5'b01000, 5'b00000, 5'b00000, 5'b00000);
    push(1025, 5'b01000, 5'b01000, 5'b00000, 5'b00000);
    push(1225, 5'b01000, 5'b00000, 5'b00000, 5'b01000);
    wait_cyc(1240); reset = 1'b1;
    push(1241, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    wait_cyc(1243); reset = 1'b0;
    push(1274, 5'b01000, 5'b00000, 5'b00000, 5'b00000);
    push(1275, 5'b01000, 5'b01000, 5'b00000, 5'b00000);
    wait_cyc(1300); btn[3] = 1'b0;
    push(1324, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    push(1325, 5'b00000, 5'b00000, 5'b01000, 5'b00000);

    wait_cyc(1400);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected events never seen, required 0 (next at cycle %0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Monitor: checks the tick every cycle, zero outputs in reset cycles, and
  // pops one expected event whenever a level changes or any pulse is high.
  initial begin
    logic [4:0] prev_lvl;
    logic       in_rst;
    logic       exp_tick;
    ev_t        e;
    prev_lvl = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        in_rst   = (cyc <= 3) || (cyc >= 1241 && cyc <= 1243);
        exp_tick = !in_rst && (cyc % 10 == 3);
        n_tests++;
        if (tick !== exp_tick) begin
          n_fail++;
          $display("FAIL tick @%0d: got %b, required %b", cyc, tick, exp_tick);
        end
        if (in_rst) begin
          n_tests++;
          if ({lvl, prs, rel, lng} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs @%0d: got lvl=%b prs=%b rel=%b lng=%b, required all 0",
                     cyc, lvl, prs, rel, lng);
          end
        end
        if (lvl !== prev_lvl || |prs || |rel || |lng) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event @%0d: got lvl=%b prs=%b rel=%b lng=%b, required no event",
                     cyc, lvl, prs, rel, lng);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.lvl !== lvl || e.prs !== prs ||
                e.rel !== rel || e.lng !== lng) begin
              n_fail++;
              $display("FAIL event: got cyc=%0d lvl=%b prs=%b rel=%b lng=%b, required cyc=%0d lvl=%b prs=%b rel=%b lng=%b",
                       cyc, lvl, prs, rel, lng, e.cyc, e.lvl, e.prs, e.rel, e.lng);
            end else begin
              $display("[TB] event @%0d lvl=%b prs=%b rel=%b lng=%b ok",
                       cyc, lvl, prs, rel, lng);
            end
          end
        end
        prev_lvl = lvl;
      end
    end
  end

endmodule
